// File: rtl/csr_hpm_unit.sv
// csr_hpm_unit
//   Machine-mode performance-monitor CSR block. It holds mcycle, minstret,
//   NUM_CNT programmable counters (mhpmcounter3..), their mhpmevent selectors
//   and the shared mcountinhibit register. A registered interrupt is raised
//   while any counter has both its overflow flag and its overflow enable set.
//
// Ports
//   clk        rising-edge clock for all state
//   RST        synchronous, active-high reset
//   csr_addr   12-bit CSR address of the current access
//   csr_op     00 nop/read, 01 write, 10 set, 11 clear
//   csr_we     access valid; a write/set/clear commits on this edge
//   csr_wdata  32-bit operand
//   csr_rdata  combinational read of the addressed CSR (0 when unmapped)
//   csr_hit    address is implemented by this block
//   retire     one instruction retired this cycle
//   event_in   EVT_W event pulses; mhpmevent SEL=s picks event_in[s-1]
//   ovf_irq    registered OR over counters of (OF & OVFIE)
module csr_hpm_unit #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned EVT_W   = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [11:0]      csr_addr,
  input  logic [1:0]       csr_op,
  input  logic             csr_we,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata,
  output logic             csr_hit,
  input  logic             retire,
  input  logic [EVT_W-1:0] event_in,
  output logic             ovf_irq
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [11:0] ADDR_INHIBIT   = 12'h320;
  localparam logic [11:0] ADDR_EVT0      = 12'h323;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_HPM0      = 12'hB03;
  localparam logic [11:0] ADDR_HPM0H     = 12'hB83;

  // CY, IR and one HPM bit per implemented counter.
  localparam logic [31:0] INH_MASK =
    32'(((64'd1 << NUM_CNT) - 64'd1) << 3) | 32'h0000_0005;
  // OF, OVFIE and SEL.
  localparam logic [31:0] EVT_MASK = 32'hC000_00FF;

  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic [CNT_W-1:0] hpm_q [NUM_CNT];
  logic [CNT_W-1:0] hpm_d [NUM_CNT];
  logic [31:0]      inhibit_q, inhibit_d;
  logic [31:0]      mhpmevent_q [NUM_CNT];
  logic [31:0]      mhpmevent_d [NUM_CNT];
  logic             irq_d;

  logic [63:0]      mcycle_w, minstret_w;
  logic [63:0]      hpm_w [NUM_CNT];

  logic             dec_inh;
  logic [1:0]       dec_cyc;   // {hi, lo}
  logic [1:0]       dec_ins;   // {hi, lo}
  logic [NUM_CNT-1:0] dec_evt, dec_lo, dec_hi;
  logic [NUM_CNT-1:0] evt_fire;
  logic [31:0]      wval;
  logic             do_wr;

  function automatic logic [63:0] widen(input logic [CNT_W-1:0] v);
    logic [63:0] t;
    t = '0;
    t[CNT_W-1:0] = v;
    return t;
  endfunction

  // Replace one 32-bit half; hi-half bits beyond the counter width fall away.
  function automatic logic [CNT_W-1:0] put_half(input logic [CNT_W-1:0] cur,
                                                input logic hi,
                                                input logic [31:0] v);
    logic [63:0] t;
    t = widen(cur);
    if (hi) t[63:32] = v;
    else    t[31:0]  = v;
    return t[CNT_W-1:0];
  endfunction

  always_comb begin
    mcycle_w   = widen(mcycle_q);
    minstret_w = widen(minstret_q);
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      hpm_w[k] = widen(hpm_q[k]);
    end
  end

  // Address decode and read mux.
  always_comb begin
    csr_hit   = 1'b0;
    csr_rdata = '0;
    dec_inh   = 1'b0;
    dec_cyc   = '0;
    dec_ins   = '0;
    dec_evt   = '0;
    dec_lo    = '0;
    dec_hi    = '0;
    case (csr_addr)
      ADDR_INHIBIT:   begin csr_hit = 1'b1; csr_rdata = inhibit_q;          dec_inh    = 1'b1; end
      ADDR_MCYCLE:    begin csr_hit = 1'b1; csr_rdata = mcycle_w[31:0];     dec_cyc[0] = 1'b1; end
      ADDR_MCYCLEH:   begin csr_hit = 1'b1; csr_rdata = mcycle_w[63:32];    dec_cyc[1] = 1'b1; end
      ADDR_MINSTRET:  begin csr_hit = 1'b1; csr_rdata = minstret_w[31:0];   dec_ins[0] = 1'b1; end
      ADDR_MINSTRETH: begin csr_hit = 1'b1; csr_rdata = minstret_w[63:32];  dec_ins[1] = 1'b1; end
      default: ;
    endcase
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      if (csr_addr == 12'(ADDR_EVT0 + k)) begin
        csr_hit    = 1'b1;
        csr_rdata  = mhpmevent_q[k];
        dec_evt[k] = 1'b1;
      end
      if (csr_addr == 12'(ADDR_HPM0 + k)) begin
        csr_hit   = 1'b1;
        csr_rdata = hpm_w[k][31:0];
        dec_lo[k] = 1'b1;
      end
      if (csr_addr == 12'(ADDR_HPM0H + k)) begin
        csr_hit   = 1'b1;
        csr_rdata = hpm_w[k][63:32];
        dec_hi[k] = 1'b1;
      end
    end
  end

  always_comb begin
    case (csr_op)
      OP_WRITE: wval = csr_wdata;
      OP_SET:   wval = csr_rdata | csr_wdata;
      OP_CLEAR: wval = csr_rdata & ~csr_wdata;
      default:  wval = csr_rdata;
    endcase
    do_wr = csr_we && csr_hit && (csr_op != OP_NOP);
  end

  // Event routing: SEL=0 or SEL beyond EVT_W never matches any line.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      evt_fire[k] = 1'b0;
      for (int unsigned e = 0; e < EVT_W; e++) begin
        if (mhpmevent_q[k][7:0] == 8'(e + 1)) evt_fire[k] = event_in[e];
      end
    end
  end

  always_comb begin
    inhibit_d = inhibit_q;
    if (do_wr && dec_inh) inhibit_d = wval & INH_MASK;

    mcycle_d = mcycle_q;
    if (do_wr && dec_cyc[0])      mcycle_d = put_half(mcycle_q, 1'b0, wval);
    else if (do_wr && dec_cyc[1]) mcycle_d = put_half(mcycle_q, 1'b1, wval);
    else if (!inhibit_q[0])       mcycle_d = mcycle_q + CNT_W'(1);

    minstret_d = minstret_q;
    if (do_wr && dec_ins[0])         minstret_d = put_half(minstret_q, 1'b0, wval);
    else if (do_wr && dec_ins[1])    minstret_d = put_half(minstret_q, 1'b1, wval);
    else if (retire && !inhibit_q[2]) minstret_d = minstret_q + CNT_W'(1);

    irq_d = 1'b0;
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      irq_d = irq_d | (mhpmevent_q[k][31] & mhpmevent_q[k][30]);

      hpm_d[k]       = hpm_q[k];
      mhpmevent_d[k] = mhpmevent_q[k];
      if (do_wr && dec_evt[k]) mhpmevent_d[k] = wval & EVT_MASK;

      if (do_wr && dec_lo[k]) begin
        hpm_d[k] = put_half(hpm_q[k], 1'b0, wval);
      end else if (do_wr && dec_hi[k]) begin
        hpm_d[k] = put_half(hpm_q[k], 1'b1, wval);
      end else if (evt_fire[k] && !inhibit_q[3 + k]) begin
        hpm_d[k] = hpm_q[k] + CNT_W'(1);
        // A wrap sets OF even when software rewrites mhpmevent this cycle.
        if (&hpm_q[k]) mhpmevent_d[k][31] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inhibit_q  <= '0;
      ovf_irq    <= 1'b0;
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        hpm_q[k]       <= '0;
        mhpmevent_q[k] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inhibit_q  <= inhibit_d;
      ovf_irq    <= irq_d;
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        hpm_q[k]       <= hpm_d[k];
        mhpmevent_q[k] <= mhpmevent_d[k];
      end
    end
  end

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Bench for csr_hpm_unit: directed sequences, a constant-expectation vector
// table and a randomized run compared against a cycle-level model.
// csr_op codes used: 0 nop, 1 write, 2 set, 3 clear.
module tb_csr_hpm_unit;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        retire = 1'b0;
  logic [15:0] event_in = '0;
  logic        ovf_irq;

  logic [11:0] d_addr = '0;
  logic [1:0]  d_op = '0;
  logic        d_we = 1'b0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_hit;
  logic        d_retire = 1'b0;
  logic [15:0] d_evt = '0;
  logic        d_irq;

  int checks = 0;
  int errors = 0;
  bit mchk = 1'b0;

  csr_hpm_unit #(.NUM_CNT(8), .CNT_W(64), .EVT_W(16)) dut (
    .clk(clk), .RST(RST), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_hit(csr_hit), .retire(retire), .event_in(event_in), .ovf_irq(ovf_irq)
  );

  csr_hpm_unit #(.NUM_CNT(2), .CNT_W(40), .EVT_W(16)) dut2 (
    .clk(clk), .RST(RST), .csr_addr(d_addr), .csr_op(d_op),
    .csr_we(d_we), .csr_wdata(d_wdata), .csr_rdata(d_rdata),
    .csr_hit(d_hit), .retire(d_retire), .event_in(d_evt), .ovf_irq(d_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state (dut: 8 counters, 64-bit, 16 events)
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [8];
  logic [31:0] m_inh;
  logic [31:0] m_evt [8];
  logic        m_irq;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic m_read(input logic [11:0] a, output logic h, output logic [31:0] v);
    int ai;
    ai = int'(a);
    h = 1'b1;
    v = '0;
    if (ai == 'h320)                     v = m_inh;
    else if (ai >= 'h323 && ai < 'h32B) v = m_evt[ai - 'h323];
    else if (ai == 'hB00)                v = m_cyc[31:0];
    else if (ai == 'hB80)                v = m_cyc[63:32];
    else if (ai == 'hB02)                v = m_ins[31:0];
    else if (ai == 'hB82)                v = m_ins[63:32];
    else if (ai >= 'hB03 && ai < 'hB0B) v = m_hpm[ai - 'hB03][31:0];
    else if (ai >= 'hB83 && ai < 'hB8B) v = m_hpm[ai - 'hB83][63:32];
    else h = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_step();
    logic h, wr, irq_n, act;
    logic [31:0] cur, nv, inh0;
    logic [31:0] evt0 [8];
    int ai, s;
    if (RST) begin
      m_cyc = '0; m_ins = '0; m_inh = '0; m_irq = 1'b0;
      for (int k = 0; k < 8; k++) begin m_hpm[k] = '0; m_evt[k] = '0; end
      return;
    end
    irq_n = 1'b0;
    for (int k = 0; k < 8; k++) irq_n = irq_n | (m_evt[k][31] & m_evt[k][30]);
    m_read(csr_addr, h, cur);
    case (csr_op)
      2'd1: nv = csr_wdata;
      2'd2: nv = cur | csr_wdata;
      2'd3: nv = cur & ~csr_wdata;
      default: nv = cur;
    endcase
    wr = csr_we && h && (csr_op != 2'd0);
    ai = int'(csr_addr);
    inh0 = m_inh;
    for (int k = 0; k < 8; k++) evt0[k] = m_evt[k];
    if (wr && ai == 'h320) m_inh = nv & 32'h0000_07FD;
    if (wr && ai == 'hB00)      m_cyc[31:0] = nv;
    else if (wr && ai == 'hB80) m_cyc[63:32] = nv;
    else if (!inh0[0])          m_cyc = m_cyc + 64'd1;
    if (wr && ai == 'hB02)      m_ins[31:0] = nv;
    else if (wr && ai == 'hB82) m_ins[63:32] = nv;
    else if (retire && !inh0[2]) m_ins = m_ins + 64'd1;
    for (int k = 0; k < 8; k++) begin
      if (wr && ai == 'h323 + k) m_evt[k] = nv & 32'hC000_00FF;
      s = int'(evt0[k][7:0]);
      act = 1'b0;
      if (s >= 1 && s <= 16) act = event_in[s - 1];
      if (wr && ai == 'hB03 + k)      m_hpm[k][31:0] = nv;
      else if (wr && ai == 'hB83 + k) m_hpm[k][63:32] = nv;
      else if (act && !inh0[3 + k]) begin
        if (m_hpm[k] == 64'hFFFF_FFFF_FFFF_FFFF) begin
          m_hpm[k] = '0;
          m_evt[k][31] = 1'b1;
        end else begin
          m_hpm[k] = m_hpm[k] + 64'd1;
        end
      end
    end
    m_irq = irq_n;
  endtask

  // One clock: optional constant checks and model checks at the negedge,
  // model step, then the edge; returns 1 time unit after the rising edge.
  task automatic cycle(input string nm, input bit crd, input bit ehit,
                       input logic [31:0] erd, input bit cirq, input bit eirq);
    logic mh;
    logic [31:0] mv;
    @(negedge clk);
    if (crd) begin
      chk1({nm, " hit"}, csr_hit, ehit);
      chk32({nm, " rdata"}, csr_rdata, erd);
    end
    if (cirq) chk1({nm, " irq"}, ovf_irq, eirq);
    if (mchk) begin
      m_read(csr_addr, mh, mv);
      chk1("model hit", csr_hit, mh);
      chk32("model rdata", csr_rdata, mv);
      chk1("model irq", ovf_irq, m_irq);
    end
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle("", 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr = a; csr_op = op; csr_we = 1'b1; csr_wdata = d;
    idle();
    csr_we = 1'b0; csr_op = 2'd0; csr_wdata = '0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  vec_t tab[$];
  logic [11:0] alist[$];

  initial begin
    // reset state
    csr_addr = 12'hB00;
    idle();
    mchk = 1'b1;
    cycle("rst_mcycle", 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);

    // ten idle cycles of mcycle counting
    RST = 1'b0;
    repeat (10) idle();
    cycle("mcycle10", 1'b1, 1'b1, 32'd10, 1'b1, 1'b0);
    csr_addr = 12'hB02;
    cycle("minstret0", 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);

    // event counting and HPM inhibit
    wr(12'h323, 2'd1, 32'h1);
    event_in = 16'h0001;
    repeat (5) idle();
    event_in = '0;
    csr_addr = 12'hB03;
    cycle("hpm3_count5", 1'b1, 1'b1, 32'd5, 1'b0, 1'b0);
    wr(12'h320, 2'd2, 32'h8);
    event_in = 16'h0001;
    repeat (5) idle();
    event_in = '0;
    csr_addr = 12'hB03;
    cycle("hpm3_inhibited", 1'b1, 1'b1, 32'd5, 1'b0, 1'b0);

    // wrap, overflow flag and interrupt
    wr(12'h320, 2'd3, 32'h8);
    wr(12'hB83, 2'd1, 32'hFFFF_FFFF);
    wr(12'hB03, 2'd1, 32'hFFFF_FFFE);
    wr(12'h323, 2'd1, 32'h4000_0001);
    event_in = 16'h0001;
    idle();
    idle();
    event_in = '0;
    csr_addr = 12'hB03;
    cycle("wrap_lo", 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
    csr_addr = 12'hB83;
    cycle("wrap_hi", 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
    csr_addr = 12'h323;
    cycle("of_set", 1'b1, 1'b1, 32'hC000_0001, 1'b1, 1'b1);
    csr_op = 2'd3; csr_we = 1'b1; csr_wdata = 32'h8000_0000;
    cycle("of_clr_cycle", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    csr_op = 2'd0; csr_we = 1'b0; csr_wdata = '0;
    cycle("irq_hold", 1'b1, 1'b1, 32'h4000_0001, 1'b1, 1'b1);
    cycle("irq_low", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // write beats a same-cycle increment; set/clear keep other fields
    event_in = 16'h0001;
    wr(12'hB03, 2'd1, 32'h100);
    event_in = '0;
    csr_addr = 12'hB03;
    cycle("write_wins", 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    wr(12'h323, 2'd2, 32'h8000_0000);
    cycle("evt_set", 1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0);
    wr(12'h323, 2'd3, 32'h4000_0000);
    cycle("evt_clr", 1'b1, 1'b1, 32'h8000_0001, 1'b0, 1'b0);

    // reduced configuration: 2 counters, 40-bit
    d_addr = 12'hB05;
    #1;
    chk1("n2_b05 hit", d_hit, 1'b0);
    chk32("n2_b05 rdata", d_rdata, 32'h0);
    d_addr = 12'h325;
    #1;
    chk1("n2_325 hit", d_hit, 1'b0);
    d_addr = 12'hB83; d_op = 2'd1; d_we = 1'b1; d_wdata = 32'hFFFF_FFFF;
    idle();
    d_we = 1'b0; d_op = 2'd0;
    #1;
    chk1("n2_b83 hit", d_hit, 1'b1);
    chk32("n2_b83 rdata", d_rdata, 32'h0000_00FF);
    d_addr = 12'h320; d_op = 2'd1; d_we = 1'b1; d_wdata = 32'hFFFF_FFFF;
    idle();
    d_we = 1'b0; d_op = 2'd0;
    #1;
    chk32("n2_inhibit", d_rdata, 32'h0000_001D);

    // reset while counting with a pending write
    event_in = 16'hFFFF; retire = 1'b1;
    csr_addr = 12'hB03; csr_op = 2'd1; csr_we = 1'b1; csr_wdata = 32'h55;
    RST = 1'b1;
    idle();
    csr_op = 2'd0; csr_we = 1'b0; csr_wdata = '0;
    cycle("rst_hpm3", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    csr_addr = 12'h323;
    cycle("rst_evt3", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    csr_addr = 12'h320;
    cycle("rst_inhibit", 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    csr_addr = 12'hB02;
    cycle("rst_minstret", 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    RST = 1'b0; event_in = '0; retire = 1'b0;

    // vector table: write then read back, all counters inhibited first
    tab.push_back('{12'h320, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0000_07FD});
    tab.push_back('{12'h323, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'hC000_00FF});
    tab.push_back('{12'h323, 2'd3, 32'h4000_0000, 1'b1, 32'h8000_00FF});
    tab.push_back('{12'h323, 2'd2, 32'h0000_0100, 1'b1, 32'h8000_00FF});
    tab.push_back('{12'h323, 2'd3, 32'h8000_0000, 1'b1, 32'h0000_00FF});
    tab.push_back('{12'hB03, 2'd1, 32'h1234_5678, 1'b1, 32'h1234_5678});
    tab.push_back('{12'hB83, 2'd1, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE});
    tab.push_back('{12'hB03, 2'd2, 32'h0000_000F, 1'b1, 32'h1234_567F});
    tab.push_back('{12'hB83, 2'd3, 32'hFFFF_0000, 1'b1, 32'h0000_BABE});
    tab.push_back('{12'hB00, 2'd1, 32'hAAAA_5555, 1'b1, 32'hAAAA_5555});
    tab.push_back('{12'h32A, 2'd1, 32'h4000_0003, 1'b1, 32'h4000_0003});
    tab.push_back('{12'h32B, 2'd1, 32'h0000_0001, 1'b0, 32'h0000_0000});
    tab.push_back('{12'hB0B, 2'd1, 32'h0000_0001, 1'b0, 32'h0000_0000});
    tab.push_back('{12'hB8A, 2'd1, 32'h0000_0001, 1'b1, 32'h0000_0001});
    tab.push_back('{12'hB01, 2'd1, 32'h0000_0001, 1'b0, 32'h0000_0000});
    tab.push_back('{12'h320, 2'd0, 32'h0000_0000, 1'b1, 32'h0000_07FD});
    tab.push_back('{12'h321, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
    for (int i = 0; i < tab.size(); i++) begin
      wr(tab[i].addr, tab[i].op, tab[i].wdata);
      csr_addr = tab[i].addr;
      cycle($sformatf("tab%0d", i), 1'b1, tab[i].hit, tab[i].rd, 1'b0, 1'b0);
    end

    // randomized run against the model
    alist = '{12'h320, 12'h321, 12'h32B, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
              12'hB01, 12'hB0B, 12'h000};
    for (int k = 0; k < 8; k++) begin
      alist.push_back(12'(12'h323 + k));
      alist.push_back(12'(12'hB03 + k));
      alist.push_back(12'(12'hB83 + k));
    end
    for (int n = 0; n < 2000; n++) begin
      csr_addr = alist[$urandom_range(0, alist.size() - 1)];
      csr_op   = 2'($urandom_range(0, 3));
      csr_we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0, 1:    csr_wdata = 32'hFFFF_FFFF;
        2:       csr_wdata = 32'hFFFF_FFFD;
        3:       csr_wdata = 32'($urandom_range(0, 20)) | 32'h4000_0000;
        default: csr_wdata = $urandom;
      endcase
      event_in = 16'($urandom);
      retire   = 1'($urandom);
      RST      = ($urandom_range(0, 299) == 0);
      idle();
    end
    RST = 1'b0; csr_we = 1'b0; csr_op = 2'd0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
